trace_capture: RTL and testbench

- Parametrised CPU execution-trace recorder for the ad1xx core.
- Samples PC, instruction word and NWATCH watched register values into a circular buffer.
- Sampling is either every retired instruction or a programmable periodic tick.
- Entries drain oldest-first over a valid/ready stream, so benches and debug logic read the trace after the run instead of polling CPU internals.

---
 rtl/trace_pkg.sv | 19 +
 rtl/trace_ram.sv | 29 ++
 rtl/trace_capture.sv | 160 ++++++++++++++++
 tb/tb_trace_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace recorder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trace_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic MODE_RETIRE   = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // One stored entry: {watch channels, instruction word, pc}.
  function automatic int entry_w(input int nwatch, input int xlen);
    return (nwatch + 1) * xlen + 32;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port RAM holding trace entries; one write port, one read port.
// Latency: write lands at the clock edge; read data is registered, one cycle after raddr.
// Backpressure: none; the read register reloads every cycle from raddr.
// Ports: clk/reset, we/waddr/wdata (write), raddr/rdata (read, rdata cleared by reset).
module trace_ram #(
  parameter int DEPTH = 32,
  parameter int W     = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_capture.sv
// CPU execution-trace recorder: samples {watch, inst, pc} into a circular buffer, drains oldest-first.
// Latency: a sample is visible on the read stream the cycle after capture ends; one pop per cycle.
// Backpressure: rd_data holds while rd_valid && !rd_ready; no reads while capturing.
// Ports: clk/reset; mode/period/wrap/arm/stop control; retire_valid/pc_in/inst_in/watch_in CPU
// state; capturing/count/overflow status; rd_valid/rd_ready/rd_data drain stream.
// Optional TRACE_CAPTURE_TRIGGER_EN adds trig_pc/post_count inputs and triggered output.
module trace_capture
  import trace_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NWATCH   = 2,
  parameter int PERIOD_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mode,
  input  logic [PERIOD_W-1:0]           period,
  input  logic                          wrap,
  input  logic                          arm,
  input  logic                          stop,
  input  logic                          retire_valid,
  input  logic [XLEN-1:0]               pc_in,
  input  logic [31:0]                   inst_in,
  input  logic [NWATCH*XLEN-1:0]        watch_in,
`ifdef TRACE_CAPTURE_TRIGGER_EN
  input  logic [XLEN-1:0]               trig_pc,
  input  logic [$clog2(DEPTH):0]        post_count,
  output logic                          triggered,
`endif
  output logic                          capturing,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [(NWATCH+1)*XLEN+31:0]   rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(NWATCH, XLEN);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t              state;
  logic [AW-1:0]       wptr, rptr, raddr;
  logic [PERIOD_W-1:0] pcnt, pmax;
  logic                full, ev, wr_en, pop, trig_end;
  logic [EW-1:0]       wdat, ram_q, byp_dat;
  logic                byp;

  // A programmed period of 0 behaves like 1 (sample every cycle).
  assign pmax  = (period == '0) ? '0 : period - 1'b1;
  assign full  = (count == FULL);
  assign wdat  = {watch_in, inst_in, pc_in};

  // arm restarts the capture, so a same-cycle sample is discarded.
  assign ev    = (state == ARMED) && !arm &&
                 ((mode == MODE_PERIODIC) ? (pcnt >= pmax) : retire_valid);
  assign wr_en = ev && (!full || wrap);

  assign capturing = (state == ARMED);
  assign rd_valid  = (count != '0) && !capturing;
  assign pop       = rd_valid && rd_ready && !arm;

  // Read address is the read pointer as it will be after this edge, so the
  // registered RAM output already shows the head entry next cycle (prefetch).
  always_comb begin
    raddr = rptr;
    if (reset || arm)                   raddr = '0;
    else if (pop || (ev && full && wrap)) raddr = rptr + 1'b1;
  end

  // The final write of a capture can target the very entry being prefetched;
  // forward the written data in that case since the RAM returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      byp     <= 1'b0;
      byp_dat <= '0;
    end else begin
      byp     <= wr_en && (wptr == raddr);
      byp_dat <= wdat;
    end
  end

  assign rd_data = byp ? byp_dat : ram_q;

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (wdat),
    .raddr (raddr),
    .rdata (ram_q)
  );

`ifdef TRACE_CAPTURE_TRIGGER_EN
  logic [CW-1:0] remain;
  logic          trig_hit;

  assign trig_hit = ev && !triggered && (pc_in == trig_pc);
  assign trig_end = ev && ((trig_hit && (post_count == '0)) ||
                           (triggered && (remain == CW'(1))));

  always_ff @(posedge clk) begin
    if (reset || arm) begin
      triggered <= 1'b0;
      remain    <= '0;
    end else if (trig_hit) begin
      triggered <= 1'b1;
      remain    <= post_count;
    end else if (ev && triggered && (remain != '0)) begin
      remain    <= remain - 1'b1;
    end
  end
`else
  assign trig_end = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      overflow <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      pcnt     <= '0;
    end else if (arm) begin
      state    <= ARMED;
      count    <= '0;
      overflow <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      pcnt     <= '0;
    end else if (state == ARMED) begin
      if (mode == MODE_PERIODIC) pcnt <= (pcnt >= pmax) ? '0 : pcnt + 1'b1;
      if (ev) begin
        if (!full) begin
          wptr  <= wptr + 1'b1;
          count <= count + 1'b1;
        end else begin
          overflow <= 1'b1;
          if (wrap) begin
            // Overwrite the oldest entry: both pointers move, count stays full.
            wptr <= wptr + 1'b1;
            rptr <= rptr + 1'b1;
          end
        end
      end
      if (stop || (ev && full && !wrap) || trig_end) begin
        state <= IDLE;
        pcnt  <= '0;
      end
    end else if (pop) begin
      rptr  <= rptr + 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 32;
  localparam int NWATCH   = 2;
  localparam int PERIOD_W = 16;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int EW       = (NWATCH + 1) * XLEN + 32;

  logic                   clk = 1'b0;
  logic                   reset, mode, wrap, arm, stop, retire_valid, rd_ready;
  logic [PERIOD_W-1:0]    period;
  logic [XLEN-1:0]        pc_in;
  logic [31:0]            inst_in;
  logic [NWATCH*XLEN-1:0] watch_in;
  logic                   capturing, overflow, rd_valid;
  logic [CW-1:0]          count;
  logic [EW-1:0]          rd_data;
`ifdef TRACE_CAPTURE_TRIGGER_EN
  logic [XLEN-1:0]        trig_pc;
  logic [CW-1:0]          post_count;
  logic                   triggered;
  bit                     m_trig;
  int                     m_left;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the buffer is just a queue of entries, oldest first.
  logic [EW-1:0]   mq[$];
  bit              m_cap, m_ovf, m_rst;
  int              m_since;
  logic [XLEN-1:0] pops[$];

  always #5 clk = ~clk;

  trace_capture #(.XLEN(XLEN), .DEPTH(DEPTH), .NWATCH(NWATCH), .PERIOD_W(PERIOD_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .period       (period),
    .wrap         (wrap),
    .arm          (arm),
    .stop         (stop),
    .retire_valid (retire_valid),
    .pc_in        (pc_in),
    .inst_in      (inst_in),
    .watch_in     (watch_in),
`ifdef TRACE_CAPTURE_TRIGGER_EN
    .trig_pc      (trig_pc),
    .post_count   (post_count),
    .triggered    (triggered),
`endif
    .capturing    (capturing),
    .count        (count),
    .overflow     (overflow),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data)
  );

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp_all();
    bit mv;
    mv = (mq.size() != 0) && !m_cap;
    check("capturing", EW'(capturing), EW'(m_cap));
    check("count", EW'(count), EW'(mq.size()));
    check("overflow", EW'(overflow), EW'(m_ovf));
    check("rd_valid", EW'(rd_valid), EW'(mv));
    if (mv)         check("rd_data", rd_data, mq[0]);
    else if (m_rst) check("rd_data_reset", rd_data, '0);
`ifdef TRACE_CAPTURE_TRIGGER_EN
    check("triggered", EW'(triggered), EW'(m_trig));
`endif
  endtask

  // Apply the current inputs to the model, clock the DUT, then compare.
  task automatic tick();
    logic [EW-1:0] ent;
    bit ev;
    int pe;
    ent = {watch_in, inst_in, pc_in};
    pe  = (period == 0) ? 1 : int'(period);
    m_rst = 1'b0;
    if (rd_valid && rd_ready && !arm && !reset) pops.push_back(rd_data[XLEN-1:0]);
    if (reset) begin
      mq.delete(); m_cap = 0; m_ovf = 0; m_rst = 1; m_since = 0;
`ifdef TRACE_CAPTURE_TRIGGER_EN
      m_trig = 0; m_left = 0;
`endif
    end else if (arm) begin
      mq.delete(); m_cap = 1; m_ovf = 0; m_since = 0;
`ifdef TRACE_CAPTURE_TRIGGER_EN
      m_trig = 0; m_left = 0;
`endif
    end else if (m_cap) begin
      m_since++;
      ev = mode ? (m_since % pe == 0) : bit'(retire_valid);
      if (ev) begin
        if (mq.size() < DEPTH) mq.push_back(ent);
        else begin
          m_ovf = 1;
          if (wrap) begin void'(mq.pop_front()); mq.push_back(ent); end
          else m_cap = 0;
        end
`ifdef TRACE_CAPTURE_TRIGGER_EN
        if (!m_trig && pc_in == trig_pc) begin
          m_trig = 1; m_left = int'(post_count);
          if (m_left == 0) m_cap = 0;
        end else if (m_trig) begin
          m_left--;
          if (m_left == 0) m_cap = 0;
        end
`endif
      end
      if (stop) m_cap = 0;
    end else if (mq.size() != 0 && rd_ready) begin
      void'(mq.pop_front());
    end
    @(posedge clk); #1;
    cmp_all();
  endtask

  task automatic cpu(input logic [XLEN-1:0] pc, input bit rv);
    pc_in = pc;
    inst_in = $urandom;
    for (int k = 0; k < NWATCH; k++) watch_in[k*XLEN +: XLEN] = $urandom;
    retire_valid = rv;
  endtask

  // pat 0: always ready, otherwise random ready.
  task automatic drain(input int pat);
    for (int c = 0; c < 400 && rd_valid; c++) begin
      rd_ready = (pat == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    rd_ready = 1'b0;
    check("drain_done", EW'(rd_valid), '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; mode = 0; wrap = 0; arm = 0; stop = 0; retire_valid = 0; rd_ready = 0;
    period = '0; pc_in = '0; inst_in = '0; watch_in = '0;
    m_cap = 0; m_ovf = 0; m_rst = 0; m_since = 0;
`ifdef TRACE_CAPTURE_TRIGGER_EN
    trig_pc = '1; post_count = '0; m_trig = 0; m_left = 0;
`endif
    repeat (2) tick();
    reset = 0;
    tick();
    check("rst_count", EW'(count), '0);

    // Retire mode, five retires, stop, drain.
    mode = 0; wrap = 0; arm = 1; tick(); arm = 0;
    for (int i = 0; i < 5; i++) begin cpu(XLEN'(4 * i), 1); tick(); end
    cpu('0, 0); stop = 1; tick(); stop = 0;
    check("t1_count", EW'(count), EW'(5));
    pops.delete();
    drain(0);
    check("t1_npops", EW'(pops.size()), EW'(5));
    for (int j = 0; j < 5 && j < pops.size(); j++) check("t1_pc", EW'(pops[j]), EW'(4 * j));

    // Periodic mode, period 100, 1000 cycles; pc_in tracks the cycle index.
    mode = 1; period = 16'd100; arm = 1; tick(); arm = 0;
    for (int n = 1; n <= 1000; n++) begin
      cpu(XLEN'(n), 0);
      stop = (n == 1000);
      tick();
    end
    stop = 0;
    check("t2_count", EW'(count), EW'(10));
    pops.delete();
    drain(1);
    check("t2_npops", EW'(pops.size()), EW'(10));
    for (int j = 0; j < 10 && j < pops.size(); j++) check("t2_pc", EW'(pops[j]), EW'(100 * (j + 1)));

    // Wrap: 40 retires into 32 entries.
    mode = 0; wrap = 1; arm = 1; tick(); arm = 0;
    for (int i = 0; i < 40; i++) begin cpu(XLEN'(4 * i), 1); tick(); end
    cpu('0, 0); stop = 1; tick(); stop = 0;
    check("t3_count", EW'(count), EW'(32));
    check("t3_overflow", EW'(overflow), EW'(1));
    pops.delete();
    drain(0);
    check("t3_npops", EW'(pops.size()), EW'(32));
    if (pops.size() == 32) begin
      check("t3_first_pc", EW'(pops[0]), EW'(32'h20));
      check("t3_last_pc", EW'(pops[31]), EW'(32'h9C));
    end

    // No wrap: 33 retires, the last is dropped and capture ends.
    wrap = 0; arm = 1; tick(); arm = 0;
    for (int i = 0; i < 33; i++) begin cpu(XLEN'(4 * i), 1); tick(); end
    cpu('0, 0);
    check("t4_count", EW'(count), EW'(32));
    check("t4_overflow", EW'(overflow), EW'(1));
    check("t4_capturing", EW'(capturing), '0);

    // Stalled drain with ready pattern 1,0,0,1, then arm during a pop.
    pops.delete();
    for (int c = 0; c < 12; c++) begin
      rd_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    check("t5_npops", EW'(pops.size()), EW'(6));
    for (int j = 0; j < pops.size(); j++) check("t5_pc", EW'(pops[j]), EW'(4 * j));
    rd_ready = 1; arm = 1; tick(); arm = 0; rd_ready = 0;
    check("t5_arm_rd_valid", EW'(rd_valid), '0);
    check("t5_arm_count", EW'(count), '0);
    stop = 1; tick(); stop = 0;

`ifdef TRACE_CAPTURE_TRIGGER_EN
    // Trigger at 0x40 with three post-trigger samples.
    mode = 0; wrap = 1; trig_pc = 32'h40; post_count = CW'(3);
    arm = 1; tick(); arm = 0;
    for (int i = 0; i < 30; i++) begin
      cpu(XLEN'(4 * i), 1); tick();
      if (i == 16) check("t6_triggered", EW'(triggered), EW'(1));
    end
    cpu('0, 0);
    check("t6_capturing", EW'(capturing), '0);
    check("t6_count", EW'(count), EW'(20));
    pops.delete();
    drain(0);
    if (pops.size() != 0) check("t6_last_pc", EW'(pops[pops.size()-1]), EW'(32'h4C));
    trig_pc = '1;
`endif

    // Randomized mix of arm/stop/reset/retires/periods and stalled reads.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 699) == 0);
      arm   = ($urandom_range(0, 79) == 0);
      if (arm) begin
        mode   = 1'($urandom_range(0, 1));
        wrap   = 1'($urandom_range(0, 1));
        period = PERIOD_W'($urandom_range(0, 6));
`ifdef TRACE_CAPTURE_TRIGGER_EN
        post_count = CW'($urandom_range(0, 5));
`endif
      end
      stop = ($urandom_range(0, 49) == 0);
      cpu($urandom, $urandom_range(0, 2) != 0);
      rd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 0; arm = 0; stop = 0; retire_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
